reg_bank_wr_arbiter: RTL and testbench

//   Shares the write port of a bank of 32-bit WE-gated registers among NUM_REQ requesters.

---
 rtl/reg_bank_wr_arbiter_pkg.sv | 20 ++
 rtl/reg_bank_wr_arbiter_rr_pick.sv | 32 +++
 rtl/reg_bank_wr_arbiter.sv | 99 +++++++++
 tb/tb_reg_bank_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_wr_arbiter_pkg.sv
// Shared defaults and FSM encodings for the register-bank write arbiter.
// Imported by reg_bank_wr_arbiter and rr_pick.
package reg_bank_wr_arbiter_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REQ  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first eligible
// requester at or after ptr, wrapping, as one-hot, as an index, and as a valid flag.
module rr_pick
  import reg_bank_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx,
  output logic               valid
);

  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!valid && eligible[idx]) begin
        valid       = 1'b1;
        win_idx     = IDX_W'(idx);
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin arbiter sharing one registered write port of a register bank.
// Optional WR_COUNT_EN adds a 16-bit wrapping count of successful writes.
module reg_bank_wr_arbiter
  import reg_bank_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      hold,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       reg_we,
  output logic [DATA_W-1:0]         reg_wdata,
  output logic                      err,
  output logic                      busy
`ifdef WR_COUNT_EN
  ,
  output logic [15:0]               wr_count
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] eligible, pick_oh;
  logic [IDX_W-1:0]   ptr, pick_idx;
  logic               pick_vld, load, addr_ok;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_data;
  state_e             state, state_nxt;

  // Masking the current grantee keeps a held req from winning twice in a row.
  assign eligible = hold ? '0 : (req & ~gnt);
  assign busy     = |(req & ~gnt);

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (pick_oh),
    .win_idx  (pick_idx),
    .valid    (pick_vld)
  );

  assign pick_addr = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign pick_data = req_data[int'(pick_idx)*DATA_W +: DATA_W];
  assign addr_ok   = int'(pick_addr) < NUM_REGS;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = pick_vld ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nxt = pick_vld ? ST_GRANT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load = (state_nxt == ST_GRANT);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt       <= '0;
      reg_we    <= '0;
      reg_wdata <= '0;
      err       <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      gnt       <= pick_oh;
      reg_we    <= addr_ok ? (NUM_REGS'(1) << pick_addr) : '0;
      err       <= ~addr_ok;
      reg_wdata <= pick_data;
      ptr       <= (int'(pick_idx) == NUM_REQ-1) ? '0 : pick_idx + IDX_W'(1);
    end else begin
      gnt    <= '0;
      reg_we <= '0;
      err    <= 1'b0;
    end
  end

`ifdef WR_COUNT_EN
  // Counts a write as the reg_we pulse completes; dropped (err) writes never count.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)     wr_count <= '0;
    else if (|reg_we) wr_count <= wr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter with NUM_REGS=6 so out-of-range
// addresses are reachable; wr_count checks are active when WR_COUNT_EN is defined.
module tb_reg_bank_wr_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 6;
  localparam int ADDR_W   = 3;

  logic                      clk = 1'b0;
  logic                      Reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      hold;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       reg_we;
  logic [DATA_W-1:0]         reg_wdata;
  logic                      err;
  logic                      busy;
`ifdef WR_COUNT_EN
  logic [15:0]               wr_count;
`endif

  int nvec = 0;
  int nerr = 0;

  reg_bank_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .hold      (hold),
    .gnt       (gnt),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .err       (err),
    .busy      (busy)
`ifdef WR_COUNT_EN
    ,
    .wr_count  (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[i]                    = 1'b1;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    req = '0; req_addr = '0; req_data = '0; hold = 1'b0;
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req = '0; req_addr = '0; req_data = '0; hold = 1'b0;
    Reset_n = 1'b0;
    #1;
    nvec++;
    if (gnt !== 4'b0 || reg_we !== 6'b0 || reg_wdata !== 32'h0 || err !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: gnt=%b we=%b wdata=%h err=%b busy=%b, want all 0", gnt, reg_we, reg_wdata, err, busy);
    end
    step();
    Reset_n = 1'b1;
    step();
    set_req(0, 3'd2, 32'h1111_2222);
    step();
    nvec++;
    if (gnt !== 4'b0001 || reg_we !== 6'b000100) begin
      nerr++;
      $display("FAIL pre_reset_grant: gnt=%b we=%b, want 0001/000100", gnt, reg_we);
    end
    #2 Reset_n = 1'b0;
    #1;
    nvec++;
    if (gnt !== 4'b0 || reg_we !== 6'b0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL async_kill: gnt=%b we=%b err=%b, want 0", gnt, reg_we, err);
    end
    step();
    Reset_n = 1'b1;
    req = '0;
    step();
    // ptr back at 0: all four requesting must pick requester 0
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), 32'(i));
    step();
    nvec++;
    if (gnt !== 4'b0001) begin
      nerr++;
      $display("FAIL ptr_after_reset: gnt=%b, want 0001", gnt);
    end
    req = '0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 3'd3, 32'hDEAD_BEEF);
    #1;
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL single_busy: busy=%b, want 1", busy);
    end
    step();
    nvec++;
    if (gnt !== 4'b0100 || reg_we !== 6'b001000 || reg_wdata !== 32'hDEAD_BEEF || err !== 1'b0) begin
      nerr++;
      $display("FAIL single_write: gnt=%b we=%b wdata=%h err=%b, want 0100/001000/deadbeef/0", gnt, reg_we, reg_wdata, err);
    end
    req = '0;
    step();
    nvec++;
    if (gnt !== 4'b0 || reg_we !== 6'b0) begin
      nerr++;
      $display("FAIL single_pulse_end: gnt=%b we=%b, want 0", gnt, reg_we);
    end
  endtask

  task automatic test_round_robin();
    int exp_w [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 1), 32'hA000_0000 + 32'(i));
    for (int s = 0; s < 5; s++) begin
      step();
      nvec++;
      if (gnt !== 4'(1 << exp_w[s]) || reg_we !== 6'(1 << (exp_w[s] + 1)) ||
          reg_wdata !== 32'hA000_0000 + 32'(exp_w[s])) begin
        nerr++;
        $display("FAIL rr_step%0d: gnt=%b we=%b wdata=%h, want winner %0d", s, gnt, reg_we, reg_wdata, exp_w[s]);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_same_req();
    do_reset();
    set_req(0, 3'd1, 32'h5555_AAAA);
    for (int s = 1; s <= 6; s++) begin
      step();
      nvec++;
      if ((s % 2) == 1) begin
        if (gnt !== 4'b0001 || reg_we !== 6'b000010) begin
          nerr++;
          $display("FAIL same_req_on%0d: gnt=%b we=%b, want 0001/000010", s, gnt, reg_we);
        end
      end else if (gnt !== 4'b0 || reg_we !== 6'b0) begin
        nerr++;
        $display("FAIL same_req_off%0d: gnt=%b we=%b, want 0", s, gnt, reg_we);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_bad_addr();
    do_reset();
    set_req(1, 3'd7, 32'hBAD0_0007);
    step();
    nvec++;
    if (gnt !== 4'b0010 || err !== 1'b1 || reg_we !== 6'b0 || reg_wdata !== 32'hBAD0_0007) begin
      nerr++;
      $display("FAIL bad_addr7: gnt=%b err=%b we=%b wdata=%h, want 0010/1/0/bad00007", gnt, err, reg_we, reg_wdata);
    end
    req = '0;
    step();
    nvec++;
    if (err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pulse_end: err=%b, want 0", err);
    end
    set_req(3, 3'd6, 32'h6);
    step();
    nvec++;
    if (gnt !== 4'b1000 || err !== 1'b1 || reg_we !== 6'b0) begin
      nerr++;
      $display("FAIL bad_addr6: gnt=%b err=%b we=%b, want 1000/1/0", gnt, err, reg_we);
    end
    req = '0;
    step();
    set_req(0, 3'd5, 32'h5);
    step();
    nvec++;
    if (gnt !== 4'b0001 || err !== 1'b0 || reg_we !== 6'b100000) begin
      nerr++;
      $display("FAIL top_addr5: gnt=%b err=%b we=%b, want 0001/0/100000", gnt, err, reg_we);
    end
    req = '0;
    step();
  endtask

  task automatic test_hold();
`ifdef WR_COUNT_EN
    logic [15:0] c0;
`endif
    do_reset();
    hold = 1'b1;
    set_req(0, 3'd0, 32'hC0);
    set_req(1, 3'd1, 32'hC1);
    for (int s = 0; s < 3; s++) begin
      step();
      nvec++;
      if (gnt !== 4'b0 || busy !== 1'b1) begin
        nerr++;
        $display("FAIL hold_%0d: gnt=%b busy=%b, want 0000/1", s, gnt, busy);
      end
    end
`ifdef WR_COUNT_EN
    c0 = wr_count;
`endif
    hold = 1'b0;
    step();
    nvec++;
    if (gnt !== 4'b0001 || reg_wdata !== 32'hC0) begin
      nerr++;
      $display("FAIL hold_release0: gnt=%b wdata=%h, want 0001/c0", gnt, reg_wdata);
    end
    step();
    nvec++;
    if (gnt !== 4'b0010 || reg_wdata !== 32'hC1) begin
      nerr++;
      $display("FAIL hold_release1: gnt=%b wdata=%h, want 0010/c1", gnt, reg_wdata);
    end
    req = '0;
    step();
    nvec++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL hold_idle: gnt=%b busy=%b, want 0/0", gnt, busy);
    end
`ifdef WR_COUNT_EN
    nvec++;
    if (wr_count !== c0 + 16'd2) begin
      nerr++;
      $display("FAIL wr_count: got %0d, want %0d", wr_count, c0 + 16'd2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_req();
    test_bad_addr();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
